// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns a simple command/response handshake into single AXI4-Lite
// read or write transactions, with at most one transaction in flight.
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RESPOND
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state, state_nxt;
    logic                    cmd_ready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [31:0]             rsp_rdata_q;
    logic [1:0]              rsp_resp_q;
    logic                    rsp_write_q;

    logic cmd_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic r_fire;
    logic wr_done;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign aw_fire  = awvalid_q && m_axi_awready;
    assign w_fire   = wvalid_q && m_axi_wready;
    assign b_fire   = (state == WR_RESP) && m_axi_bvalid;
    assign r_fire   = (state == RD_RESP) && m_axi_rvalid;
    // Either channel may already be finished; the other may complete this cycle.
    assign wr_done  = (!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (wr_done) state_nxt = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_nxt = RESPOND;
            RD_REQ:  if (m_axi_arready) state_nxt = RD_RESP;
            RD_RESP: if (m_axi_rvalid) state_nxt = RESPOND;
            RESPOND: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is a flop so it stays low while reset is held and rises one edge later.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == IDLE);
            if (cmd_fire) begin
                addr_q    <= cmd_addr & WORD_MASK;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                awvalid_q <= cmd_write;
                wvalid_q  <= cmd_write;
            end else begin
                if (aw_fire) awvalid_q <= 1'b0;
                if (w_fire)  wvalid_q  <= 1'b0;
            end
            if (b_fire) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= m_axi_bresp;
                rsp_write_q <= 1'b1;
            end else if (r_fire) begin
                rsp_rdata_q <= m_axi_rdata;
                rsp_resp_q  <= m_axi_rresp;
                rsp_write_q <= 1'b0;
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = (state == RESPOND);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_write     = rsp_write_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state == RD_REQ);
    assign m_axi_rready  = (state == RD_RESP);

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: AXI and command address width (>=3).
REQ-002 SHALL have ports ACLK (in, 1): single clock; all logic rising-edge.
REQ-003 SHALL have port ARESET (in, 1): reset, asynchronous and active-high.
REQ-004 SHALL have cmd_valid (in, 1) and cmd_ready (out, 1): command handshake.
REQ-005 SHALL have cmd_write (in, 1): 1 = write, 0 = read.
REQ-006 SHALL have cmd_addr (in, ADDR_WIDTH), cmd_wdata (in, 32) and cmd_wstrb (in, 4): command payload.
REQ-007 SHALL have rsp_valid (out, 1) and rsp_ready (in, 1): response handshake.
REQ-008 SHALL have rsp_rdata (out, 32), rsp_resp (out, 2) and rsp_write (out, 1): response payload.
REQ-009 SHALL have m_axi_awaddr/awprot/awvalid (out, ADDR_WIDTH/3/1) and m_axi_awready (in, 1).
REQ-010 SHALL have m_axi_wdata/wstrb/wvalid (out, 32/4/1) and m_axi_wready (in, 1).
REQ-011 SHALL have m_axi_bresp/bvalid (in, 2/1) and m_axi_bready (out, 1).
REQ-012 SHALL have m_axi_araddr/arprot/arvalid (out, ADDR_WIDTH/3/1) and m_axi_arready (in, 1).
REQ-013 SHALL have m_axi_rdata/rresp/rvalid (in, 32/2/1) and m_axi_rready (out, 1).

Function
REQ-014 SHALL implement FSM IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESPOND, with one transaction outstanding at most.
REQ-015 SHALL drive cmd_ready = 1 only in IDLE; on cmd_valid&&cmd_ready, SHALL latch payload and go to WR_REQ (write) or RD_REQ (read).
REQ-016 SHALL force the low 2 bits of awaddr/araddr to 0 and drive awprot/arprot = 3'b000.
REQ-017 In WR_REQ, awvalid and wvalid SHALL both be registered 1 from the first WR_REQ cycle.
REQ-018 Each of awvalid and wvalid SHALL drop independently the cycle after its own handshake; payloads SHALL be held stable while the valid is high.
REQ-019 The FSM SHALL enter WR_RESP once both AW and W handshakes have completed, in the same or in different cycles.
REQ-020 bready SHALL be 1 in WR_RESP only; on bvalid&&bready, SHALL capture bresp, set rsp_rdata = 0 and rsp_write = 1, and go to RESPOND.
REQ-021 In RD_REQ, arvalid SHALL be 1 until arready; the FSM SHALL then go to RD_RESP.
REQ-022 rready SHALL be 1 in RD_RESP only; on rvalid&&rready, SHALL capture rdata and rresp, set rsp_write = 0, and go to RESPOND.
REQ-023 In RESPOND, rsp_valid SHALL be 1 with stable payload until rsp_ready; the FSM SHALL then return to IDLE.
REQ-024 Throughput SHALL be at most one transaction per 4 ACLK cycles; no combinational path SHALL exist from any input to a valid or ready output.
REQ-025 SLVERR and DECERR responses SHALL be passed through unmodified in rsp_resp, with no retry.
REQ-026 bvalid and rvalid seen outside WR_RESP and RD_RESP SHALL be ignored, with bready and rready held at 0.

Reset
REQ-027 While ARESET = 1, SHALL hold the FSM in IDLE and drive all valid/ready outputs to 0, except cmd_ready = 0.
REQ-028 While ARESET = 1, SHALL drive all AXI address/data outputs, rsp_rdata, rsp_resp and rsp_write to 0.
REQ-029 cmd_ready SHALL rise in the first cycle after ARESET deasserts.
REQ-030 Reset mid-transaction SHALL abort immediately, with no response issued.

Verification
REQ-031 Write: cmd addr=0x07, wdata=0xDEADBEEF, wstrb=0xF; slave with awready=wready=1 and bresp=0 -> awaddr=0x04, wdata=0xDEADBEEF, rsp_valid with rsp_resp=0 and rsp_write=1.
REQ-032 Read: cmd addr=0x04; slave returns rdata=0x12345678, rresp=0 -> rsp_rdata=0x12345678, rsp_write=0.
REQ-033 Skewed write: wready 3 cycles after awready -> awvalid drops first, wvalid held, single B accepted, single response.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0; a new cmd is accepted only after the response handshake.
REQ-035 Error plus reset: bresp=2'b10 -> rsp_resp=2'b10; ARESET pulsed during RD_RESP -> arvalid/rready=0 immediately, no rsp_valid.
